// File: rtl/eeprom_i2c_slave_pkg.sv
// eeprom_i2c_slave_pkg: device code, bus constants and one-hot FSM encoding shared by the EEPROM responder
package eeprom_i2c_slave_pkg;
  localparam logic [3:0] DEV_CODE = 4'b1010;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  typedef enum logic [9:0] {
    IDLE      = 10'b00_0000_0001,
    CTRL      = 10'b00_0000_0010,
    CTRL_ACK  = 10'b00_0000_0100,
    ADDR      = 10'b00_0000_1000,
    ADDR_ACK  = 10'b00_0001_0000,
    WDATA     = 10'b00_0010_0000,
    WDATA_ACK = 10'b00_0100_0000,
    RDATA     = 10'b00_1000_0000,
    RDATA_ACK = 10'b01_0000_0000,
    WAIT      = 10'b10_0000_0000
  } state_t;
endpackage

// File: rtl/eeprom_i2c_slave_if.sv
// eeprom_i2c_slave_if: serial clock plus write-observation signals of the EEPROM responder
interface eeprom_i2c_slave_if #(parameter int ADDR_W = 11);
  logic              SCL;
  logic              BUSY;
  logic              WR_STB;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
  modport slave (input SCL, output BUSY, WR_STB, WR_ADDR, WR_DATA);
  modport master (output SCL, input BUSY, WR_STB, WR_ADDR, WR_DATA);
endinterface

// File: rtl/eeprom_i2c_slave_bus_sync.sv
// eeprom_i2c_slave_bus_sync: synchronises SCL/SDA, produces SCL edge pulses and START/STOP detection
module eeprom_i2c_slave_bus_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda,
  output logic start,
  output logic stop
);
  logic [2:0] scl_q, sda_q;
  logic scl, sda_rise, sda_fall;
  // two synchroniser flops plus one delay stage; idle bus level is high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end
  assign scl      = scl_q[1];
  assign sda      = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign sda_rise = sda_q[1] & ~sda_q[2];
  assign sda_fall = ~sda_q[1] & sda_q[2];
  assign start    = scl & sda_fall;
  assign stop     = scl & sda_rise;
endmodule

// File: rtl/eeprom_i2c_slave.sv
// eeprom_i2c_slave: 24C16-style two-wire EEPROM responder backed by a 2K x 8 array
module eeprom_i2c_slave
  import eeprom_i2c_slave_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int PAGE_W = 4,
  parameter bit ACK_EN = 1'b1
) (
  input logic CLK,
  input logic RESET,
  inout wire  SDA,
  eeprom_i2c_slave_if.slave bus
);
  state_t state, state_nx;
  logic scl_rise, scl_fall, sda, start, stop;
  logic [3:0] cnt;
  logic [6:0] shreg;
  logic [ADDR_W-1:0] ptr, wr_addr;
  logic [7:0] byte_in, rd_byte, wr_data;
  logic rw, sda_q, busy, wr_stb, wr_en;
  logic [7:0] mem [0:2**ADDR_W-1];
  eeprom_i2c_slave_bus_sync u_sync (
    .CLK(CLK), .RESET(RESET), .scl_in(bus.SCL), .sda_in(SDA),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .sda(sda), .start(start), .stop(stop)
  );
  assign SDA         = sda_q ? 1'bz : 1'b0;
  assign byte_in     = {shreg, sda};
  assign rd_byte     = mem[state == RDATA ? ptr + ADDR_W'(1) : ptr];
  assign wr_en       = state == WDATA && scl_rise && cnt == 4'd7 && !start && !stop;
  assign bus.BUSY    = busy;
  assign bus.WR_STB  = wr_stb;
  assign bus.WR_ADDR = wr_addr;
  assign bus.WR_DATA = wr_data;
  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else state <= state_nx;
  end
  // next state: START/STOP win in every state, otherwise advance on byte and ACK-slot boundaries
  always_comb begin
    state_nx = state;
    if (start) state_nx = CTRL;
    else if (stop) state_nx = IDLE;
    else case (state)
      CTRL:      if (scl_rise && cnt == 4'd7)
                   state_nx = byte_in[7:4] != DEV_CODE ? WAIT : (byte_in[0] || ACK_EN) ? CTRL_ACK : ADDR;
      CTRL_ACK:  if (scl_fall && cnt[0]) state_nx = rw ? RDATA : ADDR;
      ADDR:      if (scl_rise && cnt == 4'd7) state_nx = ACK_EN ? ADDR_ACK : WDATA;
      ADDR_ACK,
      WDATA_ACK: if (scl_fall && cnt[0]) state_nx = WDATA;
      WDATA:     if (scl_rise && cnt == 4'd7) state_nx = ACK_EN ? WDATA_ACK : WDATA;
      RDATA:     if (scl_fall && cnt == 4'd8) state_nx = ACK_EN ? RDATA_ACK : RDATA;
      RDATA_ACK: state_nx = (scl_rise && sda == NACK) ? WAIT : (scl_fall && cnt[0]) ? RDATA : RDATA_ACK;
      default:   ;
    endcase
  end
  // datapath: shift in on SCL rise, drive SDA on SCL fall; in ACK states cnt[0] marks the 9th rise seen
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy    <= 1'b0;
      sda_q   <= 1'b1;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ptr     <= '0;
      cnt     <= '0;
      shreg   <= '0;
      rw      <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        cnt   <= '0;
        sda_q <= 1'b1;
      end else if (stop) begin
        busy  <= 1'b0;
        sda_q <= 1'b1;
      end else case (state)
        CTRL, ADDR, WDATA: if (scl_rise) begin
          shreg <= byte_in[6:0];
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt <= (state == CTRL && byte_in[0] && !ACK_EN) ? 4'd1 : 4'd0;
            if (state == CTRL && byte_in[7:4] == DEV_CODE) begin
              ptr[ADDR_W-1:8] <= byte_in[ADDR_W-8:1];
              rw              <= byte_in[0];
            end
            if (state == ADDR) ptr[7:0] <= byte_in;
            if (state == WDATA) begin
              wr_stb              <= 1'b1;
              wr_addr             <= ptr;
              wr_data             <= byte_in;
              ptr[PAGE_W-1:0]     <= ptr[PAGE_W-1:0] + PAGE_W'(1);
            end
          end
        end
        CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_rise) cnt <= 4'd1;
          else if (scl_fall) begin
            cnt   <= '0;
            sda_q <= cnt[0] ? 1'b1 : ACK;
            if (cnt[0] && state == CTRL_ACK && rw) begin
              shreg <= rd_byte[6:0];
              sda_q <= rd_byte[7];
            end
          end
        RDATA: if (scl_rise) cnt <= cnt + 4'd1;
          else if (scl_fall) begin
            if (cnt == 4'd8) begin
              ptr   <= ptr + ADDR_W'(1);
              cnt   <= '0;
              shreg <= rd_byte[6:0];
              sda_q <= ACK_EN | rd_byte[7];
            end else begin
              shreg <= {shreg[5:0], 1'b0};
              sda_q <= shreg[6];
            end
          end
        RDATA_ACK: if (scl_rise) cnt <= 4'd1;
          else if (scl_fall && cnt[0]) begin
            cnt   <= '0;
            shreg <= rd_byte[6:0];
            sda_q <= rd_byte[7];
          end
        default: sda_q <= 1'b1;
      endcase
    end
  end
  // array write port: only a completed 8-bit data byte is stored
  always_ff @(posedge CLK) begin
    if (wr_en) mem[ptr] <= byte_in;
  end
endmodule
